// File: rtl/fmul_seq_if.sv
// Enable/done handshake bundle shared by the fp16 multiply and divide blocks.
// The master drives the start request and operands; the slave returns the product.
interface fmul_seq_if;
    logic        enable;
    logic [15:0] f1;
    logic [15:0] f2;
    logic [15:0] f;
    logic        done;

    modport master (
        output enable,
        output f1,
        output f2,
        input  f,
        input  done
    );

    modport slave (
        input  enable,
        input  f1,
        input  f2,
        output f,
        output done
    );
endinterface

// File: rtl/fmul_seq.sv
// Sequential fp16 multiplier: 11 shift-add steps, then one normalise/pack step.
// Truncating, subnormals read as zero, saturates on overflow, flushes on underflow.
module fmul_seq (
    input  logic       clk,
    input  logic       reset,
    fmul_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [21:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] r_f;
    logic        r_done;

    logic [10:0] w_ma;
    logic [10:0] w_mb;
    logic [21:0] w_pp;
    logic        w_n;
    logic [9:0]  w_frac;
    logic [6:0]  w_exp;
    logic        w_sign;
    logic [15:0] w_result;

    assign w_ma = {1'b1, r_a[9:0]};
    assign w_mb = {1'b1, r_b[9:0]};
    assign w_pp = {11'd0, w_ma} << r_cnt;

    // Exponent held in 7 bits so e1+e2-15+n stays in -15..48 without wrapping.
    assign w_n    = r_acc[21];
    assign w_frac = w_n ? r_acc[20:11] : r_acc[19:10];
    assign w_exp  = {2'b00, r_a[14:10]} + {2'b00, r_b[14:10]} + {6'd0, w_n} - 7'd15;
    assign w_sign = r_a[15] ^ r_b[15];

    always_comb begin
        w_result = {w_sign, 15'd0};
        if ((r_a[14:10] == 5'd0) || (r_b[14:10] == 5'd0)) begin
            w_result = {w_sign, 15'd0};
        end else if ($signed(w_exp) >= 7'sd31) begin
            w_result = {w_sign, 5'b11110, 10'h3FF};
        end else if ($signed(w_exp) <= 7'sd0) begin
            w_result = {w_sign, 15'd0};
        end else begin
            w_result = {w_sign, w_exp[4:0], w_frac};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (bus.enable) w_state_next = MUL;
            MUL:  if (r_cnt == 4'd10) w_state_next = NORM;
            NORM: w_state_next = DONE;
            DONE: if (!bus.enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= 16'd0;
            r_b    <= 16'd0;
            r_acc  <= 22'd0;
            r_cnt  <= 4'd0;
            r_f    <= 16'd0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_a   <= bus.f1;
                        r_b   <= bus.f2;
                        r_acc <= 22'd0;
                        r_cnt <= 4'd0;
                    end
                end
                MUL: begin
                    if (w_mb[r_cnt]) begin
                        r_acc <= r_acc + w_pp;
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                NORM: begin
                    r_f    <= w_result;
                    r_done <= 1'b1;
                end
                DONE: begin
                    if (!bus.enable) begin
                        r_done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.f    = r_f;
    assign bus.done = r_done;
endmodule

// File: tb/tb_fmul_seq.sv
// Directed-vector bench for fmul_seq: results, latency, handshake, mid-run reset.
module tb_fmul_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fmul_seq_if bus ();

    fmul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end else begin
            $display("ok   %s value=%h", tag, obs);
        end
    endtask

    // One full transaction; optional operand corruption during MUL and extra hold cycles.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input bit corrupt, input int hold);
        int cycles;
        bus.enable = 1'b1;
        bus.f1 = a;
        bus.f2 = b;
        @(posedge clk); #1;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            if (corrupt && cycles == 3) begin
                bus.f1 = 16'hFFFF;
                bus.f2 = 16'hFFFF;
            end
        end while (!bus.done && cycles < 40);
        check({tag, "_latency"}, 32'(cycles), 32'd12);
        check({tag, "_f"}, {16'd0, bus.f}, {16'd0, exp});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_done"}, {31'd0, bus.done}, 32'd1);
            check({tag, "_hold_f"}, {16'd0, bus.f}, {16'd0, exp});
        end
        bus.enable = 1'b0;
        bus.f1 = 16'd0;
        bus.f2 = 16'd0;
        @(posedge clk); #1;
        check({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_f_kept"}, {16'd0, bus.f}, {16'd0, exp});
    endtask

    initial begin
        int hi_cycles;
        bus.enable = 1'b0;
        bus.f1 = 16'd0;
        bus.f2 = 16'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_f", {16'd0, bus.f}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("one_x_one",   16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 0);
        run_op("1p5_x_2",     16'h3E00, 16'h4000, 16'h4200, 1'b0, 0);
        run_op("1p5_x_1p5",   16'h3E00, 16'h3E00, 16'h4080, 1'b0, 0);
        run_op("neg2_x_half", 16'hC000, 16'h3800, 16'hBC00, 1'b0, 0);
        run_op("negzero",     16'h8000, 16'h4200, 16'h8000, 1'b0, 0);
        run_op("zero",        16'h0000, 16'h4200, 16'h0000, 1'b0, 0);
        run_op("saturate",    16'h7800, 16'h4000, 16'h7BFF, 1'b0, 0);
        run_op("flush",       16'h0400, 16'h3800, 16'h0000, 1'b0, 0);
        run_op("corrupt",     16'h3E00, 16'h3E00, 16'h4080, 1'b1, 0);
        run_op("hold5",       16'hC000, 16'h3800, 16'hBC00, 1'b0, 5);
        run_op("restart",     16'h3E00, 16'h4000, 16'h4200, 1'b0, 0);

        // Short enable pulse: operation completes, done high for exactly one cycle.
        bus.enable = 1'b1;
        bus.f1 = 16'h3C00;
        bus.f2 = 16'h4000;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        hi_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) hi_cycles++;
        end
        check("pulse_done_width", 32'(hi_cycles), 32'd1);
        check("pulse_f", {16'd0, bus.f}, 32'h0000_4000);

        // Reset landing on the 6th MUL step discards the operation.
        bus.enable = 1'b1;
        bus.f1 = 16'h3E00;
        bus.f2 = 16'h3E00;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.enable = 1'b0;
        @(posedge clk); #1;
        check("midrun_reset_f", {16'd0, bus.f}, 32'd0);
        check("midrun_reset_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_op("after_reset", 16'h3E00, 16'h4000, 16'h4200, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
